// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester register-RAM arbiter.
// Both the interface and the arbiter RTL import this package.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_if.sv
// Requester and RAM signal bundle for ram_arbiter.
// The master modport is the requester/RAM side and the slave modport is the arbiter.
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();

  // Handshake: each REQ is a level request, sampled only while the arbiter is idle,
  // together with that requester's WE/ADDR/WDATA. GNT is high for the single ACCESS
  // cycle, and DONE pulses for the single cycle after it. A REQ still high at the
  // next idle edge counts as a new request.
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_opcode;
  logic [DATA_W-1:0] ram_data_out;
  state_t            dbg_state;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
    input  ram_address, ram_data_in, ram_opcode, dbg_state
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
    output ram_address, ram_data_in, ram_opcode, dbg_state
  );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational two-way winner select.
// The default is round-robin on last_grant; defining RAM_ARB_FIXED_PRIO_EN makes R0 always win.
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    grant_id = ~req0;
`else
    // On contention, hand the RAM to whoever did not have it last.
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the 16x8 register RAM between R0 (fetch) and R1 (data/loader), one op per 3 cycles.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed R0 priority instead of round-robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input logic      clk,
  input logic      rst_n,
  ram_arb_if.slave bus
);

  state_t            state;
  logic              cmd_id;
  logic              cmd_we;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              done0_q;
  logic              done1_q;
  logic              busy_q;
  logic              opcode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              grant_valid;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  ram_arb_pick u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (grant_id) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // The RAM drive registers double as the latched command, so requesters may move on after GNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_id   <= 1'b0;
      cmd_we   <= OP_READ;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      opcode_q <= OP_READ;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state    <= ST_ACCESS;
            cmd_id   <= grant_id;
            cmd_we   <= sel_we;
            addr_q   <= sel_addr;
            din_q    <= sel_wdata;
            opcode_q <= sel_we;
            gnt0_q   <= ~grant_id;
            gnt1_q   <= grant_id;
            busy_q   <= 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant <= grant_id;
`endif
          end
        end
        ST_ACCESS: begin
          if (cmd_we == OP_READ) begin
            if (cmd_id) begin
              rdata1_q <= bus.ram_data_out;
            end else begin
              rdata0_q <= bus.ram_data_out;
            end
          end
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          done0_q  <= ~cmd_id;
          done1_q  <= cmd_id;
          opcode_q <= OP_READ;
          state    <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.busy        = busy_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = din_q;
  assign bus.ram_opcode  = opcode_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios and random traffic, all checked every cycle
// against a transaction-schedule model of the arbiter and a model of the RAM contents.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = RAM_ADDR_W;
  localparam int DW = RAM_DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM: combinational read, write on the clock edge while the opcode is high.
  logic [DW-1:0] ram_mem [16];
  assign bus.ram_data_out = ram_mem[bus.ram_address];
  always @(posedge clk) if (bus.ram_opcode) ram_mem[bus.ram_address] = bus.ram_data_in;

  function automatic logic [DW-1:0] preload(input int i);
    return DW'(i * 29) ^ 8'h5A;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] pack_out(input logic g0, g1, d0, d1, b, o,
                                           input logic [AW-1:0] a, input logic [DW-1:0] di,
                                           input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    return 64'({g0, g1, d0, d1, b, o, a, di, r0, r1});
  endfunction

  // ---------------- reference model ----------------
  // Each granted op occupies the edges op_edge (grant) and op_edge+1 (data moves);
  // the next grant can happen no earlier than op_edge+3.
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] m_rdata [2];
  bit            m_last;
  bit            op_valid, op_id, op_we;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  int unsigned   op_edge, free_at, edge_cnt;
  logic [DW+1:0] exp_q[$];  // {we, id, data} per completed op

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid   = 1'b0;
      m_last     = 1'b1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      free_at    = 0;
      exp_q.delete();
    end else begin
      edge_cnt = edge_cnt + 1;
      if (op_valid && edge_cnt == op_edge + 1) begin
        if (op_we) ref_mem[op_addr] = op_wdata;
        else m_rdata[op_id] = ref_mem[op_addr];
        exp_q.push_back({op_we, op_id, op_we ? op_wdata : ref_mem[op_addr]});
      end
      if (edge_cnt >= free_at && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          op_id = 1'b0;
`else
          op_id = !m_last;
`endif
        end else begin
          op_id = bus.req1;
        end
        m_last   = op_id;
        op_we    = op_id ? bus.we1 : bus.we0;
        op_addr  = op_id ? bus.addr1 : bus.addr0;
        op_wdata = op_id ? bus.wdata1 : bus.wdata0;
        op_edge  = edge_cnt;
        free_at  = edge_cnt + 3;
        op_valid = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [DW+1:0] sb_e;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cycle_cmp",
            pack_out(bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_opcode,
                     bus.ram_address, bus.ram_data_in, bus.rdata0, bus.rdata1),
            pack_out(op_valid && edge_cnt == op_edge && !op_id,
                     op_valid && edge_cnt == op_edge && op_id,
                     op_valid && edge_cnt == op_edge + 1 && !op_id,
                     op_valid && edge_cnt == op_edge + 1 && op_id,
                     op_valid && (edge_cnt == op_edge || edge_cnt == op_edge + 1),
                     op_valid && edge_cnt == op_edge && op_we,
                     op_valid ? op_addr : '0, op_valid ? op_wdata : '0,
                     m_rdata[0], m_rdata[1]));
      if (bus.done0 || bus.done1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_done_id", bus.done1, sb_e[DW]);
          if (!sb_e[DW+1]) check("sb_rdata", bus.done1 ? bus.rdata1 : bus.rdata0, sb_e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic wait_gnt(input bit id, input int max_cycles, input string name);
    int n = 0;
    while (!(id ? bus.gnt1 : bus.gnt0) && n < max_cycles) begin
      step();
      n++;
    end
    check({name, "_gnt_timeout"}, id ? bus.gnt1 : bus.gnt0, 1);
  endtask

  function automatic logic [DW-1:0] t7_expect(input int i);
    return (i == 3) ? 8'hA5 : preload(i);
  endfunction

  int seq[$];
  int n_gnt, n_done, last_t;
  bit opc_seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    edge_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = preload(i);
      ref_mem[i] = preload(i);
    end
    #3 rst_n = 1'b0;
    repeat (3) step();

    // 1: reset state
    check("t1_reset_outputs",
          pack_out(bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_opcode,
                   bus.ram_address, bus.ram_data_in, bus.rdata0, bus.rdata1), 0);
    check("t1_reset_state", bus.dbg_state, ST_IDLE);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();
    check("t1_idle_busy", bus.busy, 0);

    // 2: R0 writes 0xA5 to address 3
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
    step();
    check("t2_gnt0", bus.gnt0, 1);
    check("t2_opcode", bus.ram_opcode, 1);
    check("t2_addr", bus.ram_address, 3);
    check("t2_din", bus.ram_data_in, 8'hA5);
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    step();
    check("t2_done0", {bus.done0, bus.gnt0, bus.ram_opcode}, 3'b100);
    step();
    check("t2_after", {bus.done0, bus.busy, bus.ram_opcode}, 3'b000);

    // 3: R1 reads address 3 back
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd3;
    step();
    check("t3_gnt1", bus.gnt1, 1);
    bus.req1 = 1'b0;
    step();
    check("t3_done1", bus.done1, 1);
    check("t3_rdata1", bus.rdata1, 8'hA5);
    repeat (4) step();
    check("t3_rdata1_held", bus.rdata1, 8'hA5);

    // 4: both requesting and held
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 4'd1; bus.addr1 = 4'd2;
    seq.delete();
    for (int t = 0; t < 30 && seq.size() < 4; t++) begin
      step();
      if (bus.gnt0) seq.push_back(0);
      if (bus.gnt1) seq.push_back(1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("t4_grant_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      check($sformatf("t4_grant%0d", i), seq[i], 0);
`else
      check($sformatf("t4_grant%0d", i), seq[i], i % 2);
`endif
    end
    repeat (3) step();

    // 5: REQ1 raised while R0 is in ACCESS
    bus.req0 = 1'b1; bus.addr0 = 4'd1;
    wait_gnt(0, 5, "t5");
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.addr1 = 4'd2;
    step();
    check("t5_no_gnt1_complete", bus.gnt1, 0);
    step();
    check("t5_no_gnt1_idle", {bus.gnt1, bus.busy}, 2'b00);
    step();
    check("t5_gnt1", bus.gnt1, 1);
    bus.req1 = 1'b0;
    repeat (3) step();

    // 6: reset during a write's ACCESS
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 8'h3C;
    wait_gnt(0, 5, "t6");
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_zero",
          pack_out(bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_opcode,
                   bus.ram_address, bus.ram_data_in, bus.rdata0, bus.rdata1), 0);
    step();
    check("t6_no_done", {bus.done0, bus.done1}, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_idle_after", {bus.busy, bus.done0, bus.done1}, 0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd3;
    step();
    check("t6_serve_gnt1", bus.gnt1, 1);
    bus.req1 = 1'b0;
    step();
    check("t6_serve_rdata1", bus.rdata1, 8'hA5);
    repeat (2) step();

    // 7: R0 reads 0..15 back to back with REQ held
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0;
    n_gnt = 0; n_done = 0; last_t = 0; opc_seen = 1'b0;
    for (int t = 0; t < 120 && n_done < 16; t++) begin
      step();
      if (bus.ram_opcode) opc_seen = 1'b1;
      if (bus.gnt0) begin
        n_gnt++;
        if (n_gnt == 16) bus.req0 = 1'b0;
        else bus.addr0 = AW'(n_gnt);
      end
      if (bus.done0) begin
        check($sformatf("t7_rdata_%0d", n_done), bus.rdata0, t7_expect(n_done));
        if (n_done > 0) check("t7_spacing", t - last_t, 3);
        last_t = t;
        n_done++;
      end
    end
    bus.req0 = 1'b0;
    check("t7_done_count", n_done, 16);
    check("t7_no_write", opc_seen, 0);
    repeat (3) step();

    // 8: random traffic against the model
    for (int t = 0; t < 600; t++) begin
      bus.req0   = ($urandom_range(0, 99) < 55);
      bus.req1   = ($urandom_range(0, 99) < 55);
      bus.we0    = 1'($urandom_range(0, 1));
      bus.we1    = 1'($urandom_range(0, 1));
      bus.addr0  = AW'($urandom_range(0, 15));
      bus.addr1  = AW'($urandom_range(0, 15));
      bus.wdata0 = DW'($urandom_range(0, 255));
      bus.wdata1 = DW'($urandom_range(0, 255));
      step();
    end
    idle_inputs();
    repeat (4) step();
    check("end_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Sequences all accesses to the 16x8 register RAM and shares it between two requesters (R0 = CPU instruction fetch, R1 = CPU data/loader port). Converts a per-requester REQ/GNT/DONE handshake into RAM ADDRESS/DATA_IN/OPCODE drive. Registers read data back to the winning requester. Sits between the control unit and the RAM instance.

Parameters:
ADDR_W, 4, RAM address width (16 locations).
DATA_W, 8, RAM word width.

Ports:
CLK  in  1  single system clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
REQ0 / REQ1  in  1  access request from R0 / R1.
WE0 / WE1  in  1  1 = write, 0 = read; sampled with REQ.
ADDR0 / ADDR1  in  ADDR_W  target address.
WDATA0 / WDATA1  in  DATA_W  write data.
GNT0 / GNT1  out  1  high for the single ACCESS cycle of that requester's operation.
DONE0 / DONE1  out  1  one-cycle completion pulse.
RDATA0 / RDATA1  out  DATA_W  read result, valid from DONE and held until that requester's next read completes.
BUSY  out  1  high whenever the FSM is not in IDLE.
RAM_ADDRESS  out  ADDR_W  to RAM ADDRESS.
RAM_DATA_IN  out  DATA_W  to RAM DATA_IN.
RAM_OPCODE  out  1  to RAM OPCODE (0 = read, 1 = write).
RAM_DATA_OUT  in  DATA_W  from RAM DATA_OUT.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; GNT*, DONE*, BUSY, RAM_OPCODE=0; RAM_ADDRESS, RAM_DATA_IN, RDATA* = 0; LAST_GRANT=1 (R0 wins the first contention).
- FSM: IDLE -> ACCESS -> COMPLETE -> IDLE.
- IDLE: if any REQ is high, pick the winner, latch its WE/ADDR/WDATA into command registers, set GNTx and go to ACCESS. Otherwise stay.
- ACCESS (1 cycle): RAM_ADDRESS=latched addr, RAM_OPCODE=latched WE, RAM_DATA_IN=latched data, GNTx=1. On the exiting edge: if read, RDATAx <= RAM_DATA_OUT. DONEx <= 1; state -> COMPLETE.
- COMPLETE (1 cycle): RAM_OPCODE=0, RAM_ADDRESS held, GNT=0, DONEx=1. On the exiting edge go to IDLE.
- Latency: REQ seen in IDLE at cycle N -> GNT in N+1 -> DONE in N+2. Throughput is one op per 3 cycles.
- RAM_OPCODE is 1 only during a write's ACCESS cycle. It is 0 at every other time, including IDLE, so the RAM is never written spuriously.
- Requester inputs may change after GNT because commands are latched. A requester must drop REQ by the edge following DONE, or it is treated as a new request.
- Arbitration (default round-robin):
  - Single request: granted.
  - Both requesting: grant the requester != LAST_GRANT.
  - LAST_GRANT updates on each grant.
- A REQ rising during ACCESS/COMPLETE is ignored until IDLE. It is not lost if still held.
- Write-then-read to the same address from different requesters returns the new data.
- Reset mid-ACCESS of a write: RAM_OPCODE drops immediately. The RAM location may already hold the new data; no DONE is issued.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN:
- Defined: R0 always wins contention; LAST_GRANT is not implemented. R1 can be starved by continuous R0 traffic.
- Undefined: round-robin as above.

Decomposition:
- Package ram_arb_pkg:
  - state enum (ST_IDLE, ST_ACCESS, ST_COMPLETE)
  - OP_READ=1'b0, OP_WRITE=1'b1
  - RAM_ADDR_W=4, RAM_DATA_W=8
- One sub-module, ram_arb_pick: combinational 2-way winner select from REQ0, REQ1 and LAST_GRANT, with the fixed-priority variant under the macro. Outputs grant_valid and grant_id.

Test Plan:
- Reset then R0 write addr 3 data 0xA5 -> GNT0 at N+1 with RAM_OPCODE=1, RAM_ADDRESS=3, RAM_DATA_IN=0xA5; DONE0 at N+2; RAM_OPCODE=0 afterwards.
- R1 read addr 3 after the previous write -> DONE1 at N+2, RDATA1=0xA5, held after REQ1 drops.
- REQ0 and REQ1 asserted simultaneously and held:
  - default: grants alternate R0, R1, R0, R1.
  - with RAM_ARB_FIXED_PRIO_EN: R0 only until REQ0 drops.
- REQ1 asserted during R0's ACCESS -> no GNT1 until the next IDLE; then GNT1 without further contention.
- RST_N pulled low during a write's ACCESS -> all outputs 0 asynchronously, no DONE; after release, BUSY=0 and the next request is served normally.
- Back-to-back reads of addresses 0..15 by R0 with REQ held continuously -> one DONE every 3 cycles; RDATA0 matches preloaded contents; RAM_OPCODE never 1.
